// File: rtl/cache_ram_wb_ctrl.sv
// Direct-mapped write-back/write-allocate cache in front of a multi-cycle word RAM.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module cache_ram_wb_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int MEM_AW  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);
  localparam int TAG_W = MEM_AW - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

  state_t              state;
  logic                r_we;
  logic [MEM_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LAT_W-1:0]    lat_cnt;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic [DATA_W-1:0]   data_arr [LINES];
  logic [DATA_W-1:0]   mem      [2**MEM_AW];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                lat_last, cmp_hit, refill_done, wb_done;

  assign idx         = r_addr[INDEX_W-1:0];
  assign tag         = r_addr[MEM_AW-1:INDEX_W];
  assign lat_last    = (lat_cnt == LAT_W'(MEM_LAT - 1));
  assign cmp_hit     = (state == COMPARE) && valid_q[idx] && (tag_arr[idx] == tag);
  assign refill_done = (state == REFILL) && lat_last;
  assign wb_done     = (state == WRITEBACK) && lat_last;
  assign req_ready   = (state == IDLE);

  // Address bits above MEM_AW alias onto the same RAM word.
  generate
    if (ADDR_W > MEM_AW) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^req_addr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      lat_cnt    <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr[MEM_AW-1:0];
          r_wdata <= req_wdata;
          state   <= COMPARE;
        end
        COMPARE: begin
          lat_cnt <= '0;
          if (cmp_hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= r_we ? r_wdata : data_arr[idx];
            if (r_we) dirty_q[idx] <= 1'b1;
            state <= IDLE;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state <= WRITEBACK;
          end else begin
            state <= REFILL;
          end
        end
        WRITEBACK: begin
          lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
          if (lat_last) state <= REFILL;
        end
        REFILL: begin
          lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
          if (lat_last) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            state        <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage and RAM contents survive reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_arr[idx] <= mem[r_addr];
      tag_arr[idx]  <= tag;
    end else if (cmp_hit && r_we) begin
      data_arr[idx] <= r_wdata;
    end
    if (wb_done) mem[{tag_arr[idx], idx}] <= data_arr[idx];
  end

`ifdef CACHE_STATS_EN
  logic refilled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refilled <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == IDLE && req_valid) refilled <= 1'b0;
      else if (refill_done)           refilled <= 1'b1;
      if (cmp_hit && !refilled && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (state == COMPARE && !cmp_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      if (wb_done && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_ram_wb_ctrl.sv
// Directed bench for cache_ram_wb_ctrl: vector table plus busy-hold and mid-refill reset sequences.
module tb_cache_ram_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int failures = 0;

  cache_ram_wb_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns cycles from accept edge to response.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 50);
    rd = resp_rdata;
  endtask

  task automatic run(input string name, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd);
    int lat;
    logic [31:0] rd;
    do_req(we, a, d, lat, rd);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    int pulses;
    logic exp_resp, exp_rdy;

    vecs[0] = '{1'b1, 32'h005, 32'hDEADBEEF, 4, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h005, 32'h0,        1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h015, 32'h0,        6, 32'hCAFE0015};
    vecs[3] = '{1'b0, 32'h005, 32'h0,        4, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h405, 32'h12345678, 1, 32'h12345678};
    vecs[5] = '{1'b0, 32'h005, 32'h0,        1, 32'h12345678};
    vecs[6] = '{1'b1, 32'h3F0, 32'hA5A5A5A5, 4, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 32'h7F0, 32'h0,        1, 32'hA5A5A5A5};
    vecs[8] = '{1'b1, 32'h015, 32'h0BADF00D, 6, 32'h0BADF00D};
    vecs[9] = '{1'b0, 32'h005, 32'h0,        6, 32'h12345678};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Seed RAM[0x015] via eviction, then reset to start from an empty cache.
    run("prep_w015", 1'b1, 32'h015, 32'hCAFE0015, 4, 32'hCAFE0015);
    run("prep_w025", 1'b1, 32'h025, 32'h11112222, 6, 32'h11112222);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef CACHE_STATS_EN
    chk("stats_rst_hit", hit_cnt, 0);
    chk("stats_rst_wb", wb_cnt, 0);
`endif

    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata);
`ifdef CACHE_STATS_EN
      if (i == 3) begin
        chk("stats_hit", hit_cnt, 1);
        chk("stats_miss", miss_cnt, 3);
        chk("stats_wb", wb_cnt, 1);
      end
`endif
    end

    // Busy hold: hit on 0x3F0, then 0x015 held valid must wait for the response edge.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3F0; req_wdata = '0;
    @(posedge clk); #1;
    req_addr = 32'h015;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      exp_resp = (k == 1) || (k == 6);
      exp_rdy  = (k == 1) || (k >= 6);
      chk($sformatf("hold_resp_k%0d", k), resp_valid, exp_resp);
      chk($sformatf("hold_ready_k%0d", k), req_ready, exp_rdy);
      if (k == 1) chk("hold_rdata1", resp_rdata, 32'hA5A5A5A5);
      if (k == 6) begin
        chk("hold_rdata2", resp_rdata, 32'h0BADF00D);
        req_valid = 1'b0;
      end
    end

    // Reset during REFILL drops the request.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h005;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_resp", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    chk("midrst_no_resp", pulses, 0);
`ifdef CACHE_STATS_EN
    chk("midrst_miss_cnt", miss_cnt, 0);
`endif
    run("after_rst_r005", 1'b0, 32'h005, 32'h0, 4, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_ram_wb_ctrl.md
Name: cache_ram_wb_ctrl

Overview:
Parametrised cache-plus-RAM subsystem. It is the next generation of the cache/RAM top level, replacing the single-cycle write-through pairing.
- Direct-mapped, write-back, write-allocate cache. One data word per line.
- Sits in front of an embedded word-addressed RAM model with configurable access latency.
- CPU side uses a valid/ready request channel and a one-cycle response pulse.

Parameters:
ADDR_W, 32, CPU word-address width
DATA_W, 32, data word width
INDEX_W, 4, cache index bits (2**INDEX_W lines)
MEM_AW, 10, RAM address bits (2**MEM_AW words); must satisfy INDEX_W < MEM_AW <= ADDR_W
MEM_LAT, 2, RAM access latency in cycles; must be >= 1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address; bits above MEM_AW-1 ignored (alias)
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  read data, or written data for writes; held until next response

Behaviour:
- Address split: index = addr[INDEX_W-1:0], tag = addr[MEM_AW-1:INDEX_W].
- Per line state: valid, dirty, tag, data.
- Reset (async, rst_n=0):
  - state=IDLE; all valid and dirty bits cleared.
  - resp_valid=0, resp_rdata=0, req_ready=1, latency counter=0.
  - RAM contents are not reset.
- IDLE: on accept edge E0, register we/addr/wdata, go to COMPARE. Inputs are ignored while req_ready=0.
- COMPARE: hit = valid[idx] && tag match.
  - Hit read: resp_rdata<=data; resp_valid pulses during E1..E2; return to IDLE at E1.
  - Hit write: data<=wdata, dirty<=1, resp_rdata<=wdata, resp_valid pulses; return to IDLE at E1.
  - Miss with victim valid and dirty: go to WRITEBACK.
  - Miss otherwise: go to REFILL.
- WRITEBACK: hold the victim's {tag, idx} address and data for MEM_LAT cycles. The RAM write commits on the last cycle. Then go to REFILL.
- REFILL: RAM read of the request address for MEM_LAT cycles. On the last cycle: line data<=RAM word, valid=1, dirty=0, tag updated. Return to COMPARE, which now hits.
- Latency, with E0 = accept edge:
  - hit: resp_valid high from E1
  - clean miss: from E(2+MEM_LAT)
  - dirty miss: from E(2+2*MEM_LAT)
- resp_valid is registered and high for exactly one cycle per accepted request. The earliest next accept is the edge ending the resp_valid cycle.
- Write miss: allocate (refill), then the COMPARE hit-write merges the data and sets dirty.
- Reset mid-operation: the in-flight request is dropped and no response is issued. A WRITEBACK not yet committed is lost. A partially performed REFILL leaves the line invalid.
- Internal RAM: single port, 2**MEM_AW x DATA_W, synchronous; read data captured on the last latency cycle.

Optional Feature:
CACHE_STATS_EN
- Defined:
  - Adds output ports hit_cnt, miss_cnt and wb_cnt, each 16 bits.
  - hit_cnt increments on a first-pass COMPARE hit. The re-compare after a refill is not counted.
  - miss_cnt increments on each COMPARE miss; wb_cnt increments on each WRITEBACK commit.
  - All counters saturate at 0xFFFF and reset to 0.
- Undefined: no counters and no ports. Otherwise functionally identical.

Test Plan:
All scenarios use defaults (INDEX_W=4, MEM_AW=10, MEM_LAT=2).
1. After reset, write 0x005 = 0xDEADBEEF -> clean miss, resp_valid at E4, resp_rdata 0xDEADBEEF. Then read 0x005 -> hit, resp_valid at E1, resp_rdata 0xDEADBEEF.
2. After test 1, read 0x015 (same index 5) -> dirty miss, resp_valid at E6, data = RAM[0x015]. Then read 0x005 -> clean miss at E4, returns 0xDEADBEEF from RAM, proving the write-back.
3. Hold req_valid=1 with a new address while busy -> req_ready=0 throughout. Exactly one resp_valid pulse per accepted request; the second request is accepted only on the edge ending the first response pulse.
4. Pull rst_n low for 1 cycle during REFILL -> resp_valid never pulses, req_ready=1 immediately. A following read of the same address misses again.
5. Write 0x405 = 0x12345678, then read 0x005 -> hit (alias, MEM_AW=10), resp_rdata 0x12345678.
6. With CACHE_STATS_EN, run sequence 1-2 -> hit_cnt=1, miss_cnt=3, wb_cnt=1.
